io_input_sampler: RTL and testbench
===================================

Name: io_input_sampler

Overview:
- Input-side peripheral block, the counterpart of the output path that carries LCD/LEDR/LEDG/HEX values toward the board pins.
- Samples the board's raw slide switches and push-buttons, then synchronizes and debounces them.
- Captures button-press events in a sticky register.
- Serves all of this to the MEM-stage load/store unit as memory-mapped read registers with 1-cycle read latency. The edge-capture register is write-1-to-clear.

Parameters:
- IO_BASE, 32'h1001_0000, base address of the 16-byte register window; bits [3:0] must be 0.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced bit changes; must be ≥1. Board top sets 1_000_000 (20 ms at 50 MHz).
- NUM_SW, 18, number of slide switches.
- NUM_BTN, 4, number of push-buttons.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_io_sw  in  NUM_SW  raw asynchronous switch levels, 1 = up
- i_io_btn  in  NUM_BTN  raw asynchronous buttons, active-low (0 = pressed)
- i_lsu_addr  in  32  byte address from MEM stage
- i_lsu_rden  in  1  load request this cycle
- i_lsu_wren  in  1  store request this cycle
- i_lsu_wdata  in  32  store data
- o_lsu_rdata  out  32  read data, valid the cycle after the request
- o_lsu_hit  out  1  registered; 1 if the previous cycle's read hit this window
- o_btn_evt  out  1  OR of all edge-capture bits (level, for polling/IRQ)

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_reset; every flop is reset only on a rising i_clk edge with i_reset=1.
- Reset values:
  - switch sync/debounce state 0; button sync/debounce state "released" (raw-domain 1)
  - all debounce counters 0, edge register 0
  - o_lsu_rdata 0, o_lsu_hit 0, o_btn_evt 0
- Synchronizer: two flops per bit on i_io_sw and i_io_btn. No other logic reads raw inputs.
- Debounce, per bit:
  - sync==db: counter cleared to 0.
  - sync!=db: counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and sync still differs, db<=sync and counter<=0.
  - Any return to equality before that point clears the counter; the glitch is rejected.
  - Latency from a raw change to db: 2+DEBOUNCE_CYCLES cycles.
- Button level presented to software: btn_lvl = ~db_btn, so 1 = pressed.
- Edge capture, per button:
  - Set when btn_lvl goes 0→1, in the same cycle db updates.
  - Release (1→0) does not set or clear.
- Register map, decoded when i_lsu_addr[31:4]==IO_BASE[31:4], offset = i_lsu_addr[3:2]:
  - 0: SW. rdata = zero-extended db_sw.
  - 1: BTN_LVL. rdata = zero-extended btn_lvl.
  - 2: BTN_EDGE. rdata = zero-extended edge. Store: edge <= edge & ~i_lsu_wdata[NUM_BTN-1:0] (W1C).
  - 3: reserved. Reads 0 with hit=1; writes ignored.
- Stores to offsets 0/1 are ignored. Byte lane/size is ignored; the full word is returned.
- Read timing:
  - Registered: o_lsu_rdata/o_lsu_hit update on the edge after i_lsu_rden=1.
  - When i_lsu_rden=0 or the address misses: o_lsu_rdata<=0, o_lsu_hit<=0.
  - Reads have no side effects; reading BTN_EDGE does not clear it.
- Simultaneous events:
  - W1C clearing bit k in the same cycle a new press sets bit k: the set wins, and the bit is 1 afterwards.
  - rden and wren both asserted: the read returns the pre-write value; the write takes effect.
- Reset mid-operation: counters and partial debounce progress are discarded. Buttons held across reset are re-detected as presses once stable for DEBOUNCE_CYCLES after the sync delay, and their edge bit sets.
- o_btn_evt = |edge, driven from the register.

Decomposition:
- Package io_in_pkg:
  - offset constants IO_OFS_SW=2'd0, IO_OFS_BTN_LVL=2'd1, IO_OFS_BTN_EDGE=2'd2
  - default IO_BASE
  - localparam function for counter width, $clog2(DEBOUNCE_CYCLES+1)
- Sub-module io_debounce: one bit, parameters DEBOUNCE_CYCLES and RESET_VAL; contains the 2-flop sync, counter and db flop. Instantiated NUM_SW+NUM_BTN times via generate.

Test Plan:
- Reset: assert i_reset 2 cycles with raw inputs arbitrary → o_lsu_rdata=0, o_lsu_hit=0, o_btn_evt=0. Read SW with i_io_sw=0 → 0.
- Switch debounce (DEBOUNCE_CYCLES=16): set i_io_sw=18'h2A5A5 → SW read is 0 before cycle 18 after the change and 32'h0002_A5A5 from cycle 18 on.
- Glitch rejection: pulse i_io_btn[1]=0 for 10 cycles then 1 → BTN_LVL stays 0 and BTN_EDGE stays 0. Hold 0 for 30 cycles → BTN_LVL=32'h2, BTN_EDGE=32'h2, o_btn_evt=1.
- W1C: edge=4'b0110. Store 32'h4 to IO_BASE+8 → BTN_EDGE reads 32'h2. Store 32'h2 → reads 0, o_btn_evt=0.
- Set-wins collision: align a store of 32'h1 to BTN_EDGE with the cycle db for button 0 becomes pressed → BTN_EDGE bit0=1 afterwards.
- Decode/latency: read IO_BASE+12 → rdata 0, hit 1 next cycle. Read IO_BASE+16 → hit 0, rdata 0. Read IO_BASE with rden=0 → hit 0.

Source files
------------

// File: rtl/io_in_pkg.sv
// io_in_pkg: shared constants and helpers for the switch/button input sampler.
// Register offsets (word index, addr[3:2]), default window base and debounce counter sizing.
package io_in_pkg;
    localparam logic [1:0]  IO_OFS_SW       = 2'd0;
    localparam logic [1:0]  IO_OFS_BTN_LVL  = 2'd1;
    localparam logic [1:0]  IO_OFS_BTN_EDGE = 2'd2;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_0000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: one-bit 2-flop synchronizer followed by a stable-count debouncer.
// Ports: i_clk/i_reset clock and sync active-high reset; i_raw asynchronous input;
//        o_db debounced level; o_upd high in the cycle before o_db takes the new value.
module io_debounce
    import io_in_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_upd
);
    localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Exposed so the owner can react on the very edge the debounced level flips.
    assign o_upd = (r_s2 != r_db) && (r_cnt == LAST);
    assign o_db  = r_db;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1  <= RESET_VAL;
            r_s2  <= RESET_VAL;
            r_db  <= RESET_VAL;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db)
                r_cnt <= '0;
            else if (o_upd) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else
                r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/io_input_sampler.sv
// io_input_sampler: debounced switches/buttons with sticky press capture, served as MMIO read registers.
// Ports: i_clk/i_reset clock and sync active-high reset; i_io_sw raw switches (1=up);
//        i_io_btn raw buttons (active-low); i_lsu_* MEM-stage load/store request;
//        o_lsu_rdata/o_lsu_hit registered read response; o_btn_evt OR of captured presses.
module io_input_sampler
    import io_in_pkg::*;
#(
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          NUM_SW          = 18,
    parameter int          NUM_BTN         = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SW-1:0]  i_io_sw,
    input  logic [NUM_BTN-1:0] i_io_btn,
    input  logic [31:0]        i_lsu_addr,
    input  logic               i_lsu_rden,
    input  logic               i_lsu_wren,
    input  logic [31:0]        i_lsu_wdata,
    output logic [31:0]        o_lsu_rdata,
    output logic               o_lsu_hit,
    output logic               o_btn_evt
);
    logic [NUM_SW-1:0]  w_db_sw;
    logic [NUM_SW-1:0]  w_sw_upd;
    logic [NUM_BTN-1:0] w_db_btn;
    logic [NUM_BTN-1:0] w_btn_upd;
    logic [NUM_BTN-1:0] w_btn_lvl;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_clr;
    logic               w_hit;
    logic [1:0]         w_ofs;
    logic [31:0]        w_rdata;
    logic               w_unused;
    logic [NUM_BTN-1:0] r_edge;
    logic [31:0]        r_rdata;
    logic               r_hit;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_db (
            .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_io_sw[i]),
            .o_db(w_db_sw[i]), .o_upd(w_sw_upd[i])
        );
    end

    // Buttons idle high, so their debounce state resets to "released".
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_db (
            .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_io_btn[i]),
            .o_db(w_db_btn[i]), .o_upd(w_btn_upd[i])
        );
    end

    // Byte lanes, upper store bits and switch update strobes carry no meaning here.
    assign w_unused = ^{i_lsu_addr[1:0], i_lsu_wdata[31:NUM_BTN], w_sw_upd};

    assign w_btn_lvl = ~w_db_btn;
    // A released bit that is about to flip becomes pressed on this edge.
    assign w_press   = w_btn_upd & w_db_btn;
    assign w_hit     = i_lsu_addr[31:4] == IO_BASE[31:4];
    assign w_ofs     = i_lsu_addr[3:2];
    assign w_clr     = (i_lsu_wren && w_hit && w_ofs == IO_OFS_BTN_EDGE) ? i_lsu_wdata[NUM_BTN-1:0] : '0;
    assign w_rdata   = (w_ofs == IO_OFS_SW)       ? 32'(w_db_sw)   :
                       (w_ofs == IO_OFS_BTN_LVL)  ? 32'(w_btn_lvl) :
                       (w_ofs == IO_OFS_BTN_EDGE) ? 32'(r_edge)    : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_edge  <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            // OR-ing presses after the clear makes a new press win over W1C.
            r_edge  <= (r_edge & ~w_clr) | w_press;
            r_rdata <= (i_lsu_rden && w_hit) ? w_rdata : '0;
            r_hit   <= i_lsu_rden && w_hit;
        end
    end

    assign o_lsu_rdata = r_rdata;
    assign o_lsu_hit   = r_hit;
    assign o_btn_evt   = |r_edge;
endmodule

// File: tb/tb_io_input_sampler.sv
// tb_io_input_sampler: scoreboard bench for io_input_sampler with directed register accesses.
module tb_io_input_sampler;
    localparam logic [31:0] BASE = 32'h1001_0000;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sw;
    logic [3:0]  btn;
    logic [31:0] addr;
    logic        rden;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        evt;

    exp_t exp_q[$];
    exp_t m;
    int   checks = 0;
    int   fails  = 0;
    logic issued = 1'b0;
    logic pend   = 1'b0;

    io_input_sampler #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(16), .NUM_SW(18), .NUM_BTN(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_io_sw(sw), .i_io_btn(btn),
        .i_lsu_addr(addr), .i_lsu_rden(rden), .i_lsu_wren(wren), .i_lsu_wdata(wdata),
        .o_lsu_rdata(rdata), .o_lsu_hit(hit), .o_btn_evt(evt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    always @(posedge clk) pend <= issued;

    always @(negedge clk) begin
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: response seen (rdata=%h hit=%b) with no expectation queued", rdata, hit);
            end else begin
                m = exp_q.pop_front();
                if (rdata !== m.d || hit !== m.h) begin
                    fails++;
                    $display("FAIL %s: got rdata=%h hit=%b, expected rdata=%h hit=%b", m.name, rdata, hit, m.d, m.h);
                end
            end
        end
    end

    // Called at a negedge; drives one request for a single cycle and returns at the next negedge.
    task automatic xact(input string name, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic eh);
        exp_t e;
        e.name = name;
        e.d    = ed;
        e.h    = eh;
        rden   = rd;
        wren   = wr;
        addr   = a;
        wdata  = wd;
        exp_q.push_back(e);
        issued = 1'b1;
        @(negedge clk);
        rden   = 1'b0;
        wren   = 1'b0;
        issued = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        rst   = 1'b1;
        sw    = 18'h15555;
        btn   = 4'b0101;
        addr  = '0;
        rden  = 1'b0;
        wren  = 1'b0;
        wdata = '0;
        idle(2);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_hit", 32'(hit), 32'h0);
        chk("rst_evt", 32'(evt), 32'h0);
        rst = 1'b0;
        sw  = '0;
        btn = 4'hF;
        xact("rst_sw", 1, 0, BASE, 0, 32'h0, 1);

        // Switch debounce: new value visible to a read captured on the 19th edge after the change.
        sw = 18'h2A5A5;
        idle(17);
        xact("sw_edge18", 1, 0, BASE, 0, 32'h0, 1);
        xact("sw_edge19", 1, 0, BASE, 0, 32'h0002_A5A5, 1);

        // Glitch shorter than the debounce window is rejected.
        btn = 4'b1101;
        idle(10);
        btn = 4'hF;
        idle(30);
        xact("glitch_lvl", 1, 0, BASE + 4, 0, 32'h0, 1);
        xact("glitch_edge", 1, 0, BASE + 8, 0, 32'h0, 1);
        chk("glitch_evt", 32'(evt), 32'h0);

        btn = 4'b1101;
        idle(30);
        xact("press1_lvl", 1, 0, BASE + 4, 0, 32'h2, 1);
        xact("press1_edge", 1, 0, BASE + 8, 0, 32'h2, 1);
        chk("press1_evt", 32'(evt), 32'h1);

        // W1C behaviour.
        btn = 4'b1001;
        idle(30);
        xact("press2_lvl", 1, 0, BASE + 4, 0, 32'h6, 1);
        xact("press2_edge", 1, 0, BASE + 8, 0, 32'h6, 1);
        xact("wr_sw_ign", 0, 1, BASE, 32'hFFFF_FFFF, 32'h0, 0);
        xact("wr_lvl_ign", 0, 1, BASE + 4, 32'hFFFF_FFFF, 32'h0, 0);
        xact("edge_after_ign", 1, 0, BASE + 8, 0, 32'h6, 1);
        xact("w1c_4", 0, 1, BASE + 8, 32'h4, 32'h0, 0);
        xact("edge_after_w1c4", 1, 0, BASE + 8, 0, 32'h2, 1);
        xact("rdwr_pre", 1, 1, BASE + 8, 32'h2, 32'h2, 1);
        xact("edge_after_w1c2", 1, 0, BASE + 8, 0, 32'h0, 1);
        chk("w1c_evt", 32'(evt), 32'h0);

        // Releases neither set nor clear captured edges.
        btn = 4'hF;
        idle(30);
        xact("rel_lvl", 1, 0, BASE + 4, 0, 32'h0, 1);
        xact("rel_edge", 1, 0, BASE + 8, 0, 32'h0, 1);
        chk("rel_evt", 32'(evt), 32'h0);

        // Clear of bit 0 lands on the same edge button 0 becomes pressed.
        btn = 4'b1110;
        idle(17);
        xact("collide_wr", 0, 1, BASE + 8, 32'h1, 32'h0, 0);
        xact("collide_edge", 1, 0, BASE + 8, 0, 32'h1, 1);
        chk("collide_evt", 32'(evt), 32'h1);

        // Decode and latency.
        xact("rsvd_rd", 1, 0, BASE + 12, 0, 32'h0, 1);
        xact("rsvd_rw", 1, 1, BASE + 12, 32'hFFFF_FFFF, 32'h0, 1);
        xact("miss_rd", 1, 0, BASE + 16, 0, 32'h0, 0);
        xact("no_rden", 0, 0, BASE, 0, 32'h0, 0);
        xact("edge_kept", 1, 0, BASE + 8, 0, 32'h1, 1);

        // Reset mid-operation with button 0 held and a switch change in flight.
        sw = 18'h00001;
        idle(5);
        rst = 1'b1;
        idle(2);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_evt", 32'(evt), 32'h0);
        rst = 1'b0;
        xact("post_rst_edge", 1, 0, BASE + 8, 0, 32'h0, 1);
        idle(15);
        xact("redetect_e17", 1, 0, BASE + 4, 0, 32'h0, 1);
        xact("redetect_e18", 1, 0, BASE + 4, 0, 32'h0, 1);
        xact("redetect_lvl", 1, 0, BASE + 4, 0, 32'h1, 1);
        xact("redetect_edge", 1, 0, BASE + 8, 0, 32'h1, 1);
        xact("post_rst_sw", 1, 0, BASE, 0, 32'h1, 1);
        chk("redetect_evt", 32'(evt), 32'h1);

        idle(2);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
